// File: rtl/div_ctrl.sv
// div_ctrl: EX-to-divider sequencer with div-by-zero bypass, flush abort, timeout; DIV_RESULT_CACHE_EN adds a one-entry result cache
module div_ctrl #(
  parameter int WIDTH        = 32,
  parameter int CORE_TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               resp_valid_o,
  output logic [WIDTH-1:0]   resp_data_o,
  output logic               core_start_o,
  output logic               core_cancel_o,
  output logic               core_signed_o,
  output logic [WIDTH-1:0]   core_op1_o,
  output logic [WIDTH-1:0]   core_op2_o,
  input  logic [2*WIDTH-1:0] core_result_i,
  input  logic               core_done_i,
  output logic               timeout_o
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, DRAIN = 2'd3;
  localparam int CW = $clog2(CORE_TIMEOUT + 1);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
  logic             signed_q, signed_d, rem_q, rem_d, timeout_q, timeout_d;
  logic             accept, dz, hit, done, tmo;
  logic [WIDTH-1:0] hit_data;
`ifdef DIV_RESULT_CACHE_EN
  logic             cv_q, cv_d, cs_q, cs_d;
  logic [WIDTH-1:0] c1_q, c1_d, c2_q, c2_d, cq_q, cq_d, cr_q, cr_d;
  assign hit      = cv_q && cs_q == !op_i[1] && c1_q == src1_i && c2_q == src2_i;
  assign hit_data = op_i[0] ? cr_q : cq_q;
  always_comb begin
    cv_d = cv_q | done;
    cs_d = done ? signed_q : cs_q;
    c1_d = done ? op1_q : c1_q;
    c2_d = done ? op2_q : c2_q;
    cq_d = done ? core_result_i[WIDTH-1:0] : cq_q;
    cr_d = done ? core_result_i[2*WIDTH-1:WIDTH] : cr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q <= 1'b0;
      cs_q <= 1'b0;
      c1_q <= '0;
      c2_q <= '0;
      cq_q <= '0;
      cr_q <= '0;
    end else begin
      cv_q <= cv_d;
      cs_q <= cs_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      cq_q <= cq_d;
      cr_q <= cr_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif
  assign accept = state_q == IDLE && req_i && !flush_i;
  assign dz     = ~|src2_i;
  // flush outranks both completion and timeout
  assign done   = state_q == BUSY && !flush_i && core_done_i;
  assign tmo    = state_q == BUSY && !flush_i && !core_done_i && cnt_q == CW'(CORE_TIMEOUT - 1);
  always_comb begin
    case (state_q)
      IDLE:    state_d = accept ? ((dz || hit) ? RESP : BUSY) : IDLE;
      BUSY:    state_d = flush_i ? DRAIN : (done || tmo) ? RESP : BUSY;
      RESP:    state_d = core_done_i ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d     = state_q == BUSY ? cnt_q + CW'(1) : '0;
    op1_d     = accept ? src1_i : op1_q;
    op2_d     = accept ? src2_i : op2_q;
    signed_d  = accept ? !op_i[1] : signed_q;
    rem_d     = accept ? op_i[0] : rem_q;
    data_d    = accept ? (dz ? (op_i[0] ? src1_i : '1) : hit_data)
              : done   ? (rem_q ? core_result_i[2*WIDTH-1:WIDTH] : core_result_i[WIDTH-1:0])
              : tmo    ? (rem_q ? op1_q : '1)
              : data_q;
    timeout_d = timeout_q | tmo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      signed_q  <= 1'b0;
      rem_q     <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      signed_q  <= signed_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
    end
  end
  assign resp_valid_o  = state_q == RESP && !flush_i;
  assign resp_data_o   = data_q;
  assign core_start_o  = state_q == BUSY && !flush_i;
  assign core_cancel_o = state_q == BUSY && flush_i;
  assign core_signed_o = signed_q;
  assign core_op1_o    = op1_q;
  assign core_op2_o    = op2_q;
  assign timeout_o     = timeout_q;
  assign stall_o       = req_i && !resp_valid_o && !flush_i;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a fixed-latency behavioural divider core
module tb_div_ctrl;
  localparam int W = 32, LAT = 16, TO = 40;
`ifdef DIV_RESULT_CACHE_EN
  localparam int CACHE = 1;
`else
  localparam int CACHE = 0;
`endif
  logic clk = 0, rst = 1, req = 0, flush = 0, withhold = 0, start_d = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic stall_o, resp_valid_o, core_start_o, core_cancel_o, core_signed_o, core_done, timeout_o;
  logic [W-1:0] resp_data_o, core_op1_o, core_op2_o;
  logic [2*W-1:0] core_result;
  logic [W-1:0] exp_q[$];
  int ccnt = 0, starts = 0, cancels = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  div_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req), .op_i(op), .src1_i(a), .src2_i(b), .flush_i(flush),
    .stall_o(stall_o), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .core_start_o(core_start_o), .core_cancel_o(core_cancel_o), .core_signed_o(core_signed_o),
    .core_op1_o(core_op1_o), .core_op2_o(core_op2_o), .core_result_i(core_result),
    .core_done_i(core_done), .timeout_o(timeout_o)
  );
  function automatic logic [2*W-1:0] divmod(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return {x, {W{1'b1}}};
    return s ? {W'(sx % sy), W'(sx / sy)} : {x % y, x / y};
  endfunction
  // core model: done is raised LAT cycles after start and held two cycles so RESP exercises DRAIN
  always @(posedge clk) begin
    ccnt    <= (!core_start_o || core_cancel_o) ? 0 : ccnt + 1;
    start_d <= core_start_o;
    if (core_start_o && !start_d) starts <= starts + 1;
    if (core_cancel_o) cancels <= cancels + 1;
  end
  assign core_done   = !withhold && ccnt >= LAT && ccnt <= LAT + 1;
  assign core_result = divmod(core_signed_o, core_op1_o, core_op2_o);
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (resp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h, expected no response", resp_data_o);
      end else chk("resp_data", resp_data_o, exp_q.pop_front());
    end
  end
  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] exp, input int lat);
    int n = 0;
    exp_q.push_back(exp);
    op = o;
    a = x;
    b = y;
    req = 1;
    @(negedge clk);
    while (!resp_valid_o && n < 100) begin
      chk({name, "_stall"}, W'(stall_o), 1);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, W'(n), W'(lat));
    chk({name, "_stall_release"}, W'(stall_o), 0);
    @(posedge clk);
    #1 req = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int s0, c0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", W'(resp_valid_o), 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_start", W'(core_start_o), 0);
    chk("rst_cancel", W'(core_cancel_o), 0);
    chk("rst_signed", W'(core_signed_o), 0);
    chk("rst_op1", core_op1_o, 0);
    chk("rst_timeout", W'(timeout_o), 0);
    @(posedge clk);
    #1 rst = 0;
    run("divw_neg7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT + 2);
    run("modwu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, LAT + 2);
    s0 = starts;
    run("divwu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, CACHE ? 1 : LAT + 2);
    chk("cache_starts", W'(starts - s0), W'(1 - CACHE));
    s0 = starts;
    run("divw_by0", 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run("modw_by0", 2'b01, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    chk("by0_starts", W'(starts - s0), 0);
    c0 = cancels;
    op = 2'b00;
    a = 32'd1000;
    b = 32'd3;
    req = 1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    chk("flush_cancel", W'(core_cancel_o), 1);
    chk("flush_start", W'(core_start_o), 0);
    chk("flush_stall", W'(stall_o), 0);
    @(posedge clk);
    #1 flush = 0;
    req = 0;
    @(negedge clk);
    chk("flush_cancel_drop", W'(core_cancel_o), 0);
    @(posedge clk);
    @(negedge clk);
    chk("flush_state_idle", W'(dut.state_q), 0);
    chk("flush_cancel_count", W'(cancels - c0), 1);
    @(posedge clk);
    #1;
    run("divwu_9_3", 2'b10, 32'd9, 32'd3, 32'd3, LAT + 2);
    withhold = 1;
    chk("timeout_before", W'(timeout_o), 0);
    run("timeout_div", 2'b00, 32'd50, 32'd5, 32'hFFFF_FFFF, TO + 1);
    chk("timeout_after", W'(timeout_o), 1);
    withhold = 0;
    op = 2'b10;
    a = 32'd77;
    b = 32'd7;
    req = 1;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_state", W'(dut.state_q), 0);
    chk("mid_rst_start", W'(core_start_o), 0);
    chk("mid_rst_timeout", W'(timeout_o), 0);
    chk("mid_rst_data", resp_data_o, 0);
    chk("mid_rst_op2", core_op2_o, 0);
    chk("mid_rst_stall", W'(stall_o), 0);
    @(posedge clk);
    #1 rst = 0;
    run("modwu_after_rst", 2'b11, 32'd100, 32'd7, 32'd2, LAT + 2);
    chk("queue_empty", W'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
